// File: rtl/hazard_if.sv
// Handshake bundle between ID-stage decode and the hazard/forwarding controller.
// Carries stall_cnt only when HAZARD_STALL_CNT_EN is defined.
interface hazard_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic [RA_W-1:0]  id_rn;
  logic             id_flush;
  logic             loaddepen;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_flush,
    input  loaddepen, fwda, fwdb, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_flush,
    output loaddepen, fwda, fwdb, stall_cnt
  );
`else
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_flush,
    input  loaddepen, fwda, fwdb
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_flush,
    output loaddepen, fwda, fwdb
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and ID-stage forwarding select for the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     clrn,
  hazard_if.slave  hz
);

  // Shadow copies of the EX and MEM destination info
  logic            ewreg_q, em2reg_q, mwreg_q, mm2reg_q;
  logic [RA_W-1:0] ern_q, mrn_q;
  logic            ewreg_d, em2reg_d, mwreg_d, mm2reg_d;
  logic [RA_W-1:0] ern_d, mrn_d;
  logic            loaddepen_s;
  logic [1:0]      fwda_s, fwdb_s;

  // Youngest non-load producer wins; r0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic            use_src,
    input logic [RA_W-1:0] src,
    input logic            ewreg, em2reg,
    input logic [RA_W-1:0] ern,
    input logic            mwreg, mm2reg,
    input logic [RA_W-1:0] mrn
  );
    logic [1:0] sel;
    if (!use_src) begin
      sel = 2'b00;
    end else if (ewreg && !em2reg && (ern != {RA_W{1'b0}}) && (ern == src)) begin
      sel = 2'b01;
    end else if (mwreg && mm2reg && (mrn != {RA_W{1'b0}}) && (mrn == src)) begin
      sel = 2'b11;
    end else if (mwreg && !mm2reg && (mrn != {RA_W{1'b0}}) && (mrn == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Stall detection, forwarding selects and next shadow-slot contents
  always_comb begin
    loaddepen_s = 1'b0;
    ewreg_d     = 1'b0;
    em2reg_d    = 1'b0;
    ern_d       = {RA_W{1'b0}};
    if (ewreg_q && em2reg_q && (ern_q != {RA_W{1'b0}}) &&
        ((hz.id_use_rs && (ern_q == hz.id_rs)) || (hz.id_use_rt && (ern_q == hz.id_rt)))) begin
      loaddepen_s = 1'b1;
    end else begin
      loaddepen_s = 1'b0;
    end
    fwda_s = fwd_sel(hz.id_use_rs, hz.id_rs, ewreg_q, em2reg_q, ern_q, mwreg_q, mm2reg_q, mrn_q);
    fwdb_s = fwd_sel(hz.id_use_rt, hz.id_rt, ewreg_q, em2reg_q, ern_q, mwreg_q, mm2reg_q, mrn_q);
    // A stalled or squashed instruction leaves a bubble behind it
    if (!loaddepen_s && !hz.id_flush) begin
      ewreg_d  = hz.id_wreg;
      em2reg_d = hz.id_m2reg;
      ern_d    = hz.id_rn;
    end else begin
      ewreg_d  = 1'b0;
      em2reg_d = 1'b0;
      ern_d    = {RA_W{1'b0}};
    end
    mwreg_d  = ewreg_q;
    mm2reg_d = em2reg_q;
    mrn_d    = ern_q;
  end

  // Shadow slot registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ewreg_q  <= 1'b0;
      em2reg_q <= 1'b0;
      ern_q    <= {RA_W{1'b0}};
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mrn_q    <= {RA_W{1'b0}};
    end else begin
      ewreg_q  <= ewreg_d;
      em2reg_q <= em2reg_d;
      ern_q    <= ern_d;
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mrn_q    <= mrn_d;
    end
  end

  assign hz.loaddepen = loaddepen_s;
  assign hz.fwda      = fwda_s;
  assign hz.fwdb      = fwdb_s;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Stall cycle counter, wraps naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (loaddepen_s) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs queued per driven ID instruction.
// Checks stall_cnt only when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_ctrl;

  logic clk;
  logic clrn;

  hazard_if #(.RA_W(5), .CNT_W(32)) hz ();

  hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .hz   (hz)
  );

  typedef struct {
    logic        ld;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  logic [31:0] exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic ld, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.ld  = ld;
    e.fa  = fa;
    e.fb  = fb;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, ".ld"}, {31'd0, hz.loaddepen}, {31'd0, e.ld});
      check_eq({tag, ".fwda"}, {30'd0, hz.fwda}, {30'd0, e.fa});
      check_eq({tag, ".fwdb"}, {30'd0, hz.fwdb}, {30'd0, e.fb});
`ifdef HAZARD_STALL_CNT_EN
      check_eq({tag, ".cnt"}, hz.stall_cnt, e.cnt);
`endif
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic wr, input logic m2, input logic [4:0] rn, input logic fl);
    hz.id_rs     = rs;
    hz.id_rt     = rt;
    hz.id_use_rs = urs;
    hz.id_use_rt = urt;
    hz.id_wreg   = wr;
    hz.id_m2reg  = m2;
    hz.id_rn     = rn;
    hz.id_flush  = fl;
  endtask

  // One ID cycle: drive, queue expectation, sample away from the edge
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr, input logic m2,
                      input logic [4:0] rn, input logic fl,
                      input logic eld, input logic [1:0] efa, input logic [1:0] efb);
    @(negedge clk);
    drive(rs, rt, urs, urt, wr, m2, rn, fl);
    push_exp(eld, efa, efb);
    #1;
    pop_cmp(tag);
    if (eld) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 32'd0;
    clrn    = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      push_exp(1'b0, 2'b00, 2'b00);
      #1;
      pop_cmp("reset");
    end
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    clrn = 1'b1;

    //        tag         rs     rt     urs   urt   wr    m2    rn     fl     ld    fa     fb
    step("lw_r3",       5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 1'b1, 5'd3,  1'b0,  1'b0, 2'b00, 2'b00);
    step("use_stall",   5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0,  1'b1, 2'b00, 2'b00);
    step("use_fwd11",   5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0,  1'b0, 2'b11, 2'b00);
    step("add_r2",      5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 5'd2,  1'b0,  1'b0, 2'b01, 2'b01);
    step("sub_e01",     5'd2,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 5'd6,  1'b0,  1'b0, 2'b01, 2'b01);
    step("add_r2b",     5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd2,  1'b0,  1'b0, 2'b00, 2'b00);
    step("unrel",       5'd1,  5'd1,  1'b1, 1'b1, 1'b1, 1'b0, 5'd9,  1'b0,  1'b0, 2'b00, 2'b00);
    step("m_fwd10",     5'd2,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 5'd7,  1'b0,  1'b0, 2'b10, 2'b10);
    step("or_r7",       5'd8,  5'd8,  1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  1'b0,  1'b0, 2'b00, 2'b00);
    step("e_priority",  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0,  1'b0, 2'b01, 2'b01);
    step("prod_r0",     5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0,  1'b0, 2'b00, 2'b00);
    step("r0_e_alu",    5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0,  1'b0, 2'b00, 2'b00);
    step("r0_e_load",   5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0,  1'b0, 2'b00, 2'b00);
    step("r0_m_load",   5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0,  1'b0, 2'b00, 2'b00);
    step("lw_r4",       5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0,  1'b0, 2'b00, 2'b00);
    step("flush_ld",    5'd4,  5'd1,  1'b1, 1'b0, 1'b1, 1'b0, 5'd9,  1'b1,  1'b1, 2'b00, 2'b00);
    step("post_flush",  5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0,  1'b0, 2'b00, 2'b00);
    step("lw_r6",       5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  1'b0,  1'b0, 2'b00, 2'b00);

    // Reset while a stall is showing
    @(negedge clk);
    drive(5'd6, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0);
    push_exp(1'b1, 2'b00, 2'b00);
    #1;
    pop_cmp("pre_rst");
    clrn    = 1'b0;
    exp_cnt = 32'd0;
    push_exp(1'b0, 2'b00, 2'b00);
    #1;
    pop_cmp("mid_rst");
    @(negedge clk);
    clrn = 1'b1;
    step("after_rst",   5'd6,  5'd1,  1'b1, 1'b0, 1'b1, 1'b0, 5'd8,  1'b0,  1'b0, 2'b00, 2'b00);

    // Back-to-back loads, each consumed by the next
    step("lw_r10",      5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0,  1'b0, 2'b00, 2'b00);
    step("lw11_stall",  5'd10, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0,  1'b1, 2'b00, 2'b00);
    step("lw11_go",     5'd10, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0,  1'b0, 2'b11, 2'b00);
    step("add_stall",   5'd1,  5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 1'b0,  1'b1, 2'b00, 2'b00);
    step("add_go",      5'd1,  5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 1'b0,  1'b0, 2'b00, 2'b11);
    step("tail",        5'd12, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0,  1'b0, 2'b01, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
